// File: rtl/uart_rx_writer.sv
// UART 8N1 receiver that writes each received byte to consecutive memory addresses; a NUL byte ends the message.
// Latency: 2-cycle input synchroniser; we pulses one cycle after the mid-stop-bit sample.
// Backpressure: none. The write port must accept a write on every we pulse. Optional even parity via UART_RX_PARITY_EN.
module uart_rx_writer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [7:0]            data,
    output logic                  we,
    output logic                  done,
    output logic                  idle,
    output logic                  frame_err,
    output logic                  parity_err
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic                  rx_meta_q, rx_s_q;
    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            shift_q, shift_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic                  we_q, we_d;
    logic                  done_q, done_d;
    logic                  ferr_q, ferr_d;
    logic                  perr_q, perr_d;
    logic                  par_bad;

`ifdef UART_RX_PARITY_EN
    logic                  par_q, par_d;
    // Even parity: the 8 data bits plus the parity bit must XOR to zero.
    assign par_bad = ^{shift_q, par_q};
`else
    assign par_bad = 1'b0;
`endif

    // Next-state logic: receive FSM, baud counter, shift register and write-address bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        perr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif
        // The address advances the cycle after a write so the write itself sees the old value;
        // a NUL write ends the message and rewinds to 0. Wrap at the top is plain modulo arithmetic.
        if (we_q) begin
            addr_d = done_q ? '0 : addr_q + ADDR_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (cnt_q == HALF_BIT) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d = '0;
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end else begin
                        state_d = S_IDLE;
                    end
                    if (par_bad) begin
                        perr_d = 1'b1;
                    end else if (rx_s_q) begin
                        we_d   = 1'b1;
                        data_d = shift_q;
                        done_d = (shift_q == 8'h00);
                    end
                end
            end
            S_BREAK: begin
                // A held-low line reports one frame error, then waits for idle.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; the synchroniser resets to the idle level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= 3'd0;
            shift_q   <= 8'h00;
            addr_q    <= '0;
            data_q    <= 8'h00;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            done_q    <= done_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign address    = addr_q;
    assign data       = data_q;
    assign we         = we_q;
    assign done       = done_q;
    assign idle       = (state_q == S_IDLE);
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;

endmodule

// File: doc/uart_rx_writer.md
Name: uart_rx_writer

Overview:
- Receive side of the UART link driven by uart_tx: 8N1 serial input, LSB first, idle-high line.
- Each valid byte is written through a memory write port (address, data, we).
- The address increments per byte, so a NUL-terminated string lands in consecutive locations starting at 0.
- A NUL byte ends the message: it is written, done pulses, and the address returns to 0. Counterpart to uart_tx's address/data read port.

Parameters:
CLKS_PER_BIT, 8, clock cycles per serial bit; must be even and >= 4; must match uart_tx
ADDR_WIDTH, 8, write address width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
address  output  ADDR_WIDTH  write address of current byte
data  output  8  received byte
we  output  1  one-cycle write strobe; address/data valid while high
done  output  1  one-cycle pulse, coincident with we of the NUL byte
idle  output  1  high in IDLE state
frame_err  output  1  one-cycle pulse on bad stop bit
parity_err  output  1  one-cycle pulse on parity mismatch (tied 0 unless UART_RX_PARITY_EN)

Behaviour:
- Reset: one clock with rst_n=0 at a rising edge gives address=0, data=0, we=0, done=0, frame_err=0, parity_err=0, idle=1, state=IDLE, synchroniser flops=1.
  - rst_n low mid-frame aborts the frame; the partial byte is never written.
- Input: rx passes a 2-flop synchroniser (rx_s). All decisions use rx_s. There is 2 cycles of input latency.
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts on each state entry.
- States:
  - IDLE: leaves when rx_s=0, goes to START, counter cleared.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), sample rx_s.
    - rx_s=1: glitch/false start; return to IDLE, no strobe.
    - rx_s=0: go to DATA; counter and bit index cleared.
  - DATA: every CLKS_PER_BIT cycles sample rx_s into shift register bit[index], LSB first. After bit 7, go to PARITY if enabled, else STOP.
  - PARITY (macro only): one bit period later sample the parity bit, then go to STOP.
  - STOP: one bit period later sample rx_s.
    - rx_s=1 and no parity error: next cycle we=1, data=byte, address=current; go to IDLE.
    - rx_s=0: frame_err pulse, no write; go to BREAK.
  - BREAK: wait for rx_s=1, then IDLE. A held-low line produces exactly one frame_err.
- Address rules:
  - Address increments the cycle after we, so each write uses the pre-increment value.
  - If data==8'h00 at we: done=1 the same cycle, and address becomes 0 instead of incrementing.
  - Wrap: address 2^ADDR_WIDTH-1 increments to 0 and done is not asserted.
- Errors never change address.
- Back-to-back frames: the next start bit may fall in the cycle right after the stop mid-sample. IDLE handles it, so there is no frame loss with zero-length stop gap beyond one bit.
- we, done and err outputs are single-cycle pulses. data holds its value until the next write.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - One even-parity bit is expected between data bit 7 and stop.
  - If XOR(data, parity bit)=1: parity_err pulses one cycle after the stop sample, no write, address unchanged. Receiver returns to IDLE, or to BREAK if the stop bit is also bad, in which case frame_err pulses the same cycle.
- Undefined: no PARITY state, 10-bit frame, parity_err constant 0.

Test Plan:
- rst_n=0 one cycle with rx toggling -> all outputs at reset values, idle=1; rst_n released with rx=1 -> stays IDLE.
- CLKS_PER_BIT=8, uart_tx sending "Hello, World!\0" -> 14 we pulses, addresses 0..13, data 'H'(0x48)...'!'(0x21), 0x00. done only with address 13. address=0 afterwards.
- rx low for 3 cycles then high -> START rejects at mid-sample; no we; idle returns to 1 within 8 cycles.
- Frame 0x55 with stop bit forced 0 -> frame_err one pulse, no we, address unchanged. Line held low 50 cycles then high -> still one pulse; next frame 0x41 written at the same address.
- 256 non-NUL bytes with ADDR_WIDTH=8 -> last write at address 255, address wraps to 0, done never asserted.
- UART_RX_PARITY_EN: 0x03 with parity 0 -> we, data=0x03. 0x03 with parity 1 -> parity_err pulse, no we. rst_n low during bit 4 -> no write, idle=1 after reset.
